i2c_reg_bank: RTL and testbench

Parametrised register bank behind the i2c_slave byte interface, on the same mod_clk domain as the slave. Maps a byte address space into a read/write region followed by a read-only region. It adds three things:
- edge-qualified write commit;
- per-register write strobes;
- atomic snapshot of multi-byte read-only values (e.g. fpga_version, status counters), so a host reading several bytes never sees a torn value.

It also counts illegal writes for debug.

---
 rtl/i2c_reg_pkg.sv | 21 ++
 rtl/i2c_ro_snapshot.sv | 70 +++++++
 rtl/i2c_reg_bank.sv | 110 +++++++++++
 tb/tb_i2c_reg_bank.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_reg_pkg.sv
// Shared widths, transfer-direction codes and default parameter values for
// the i2c_slave register bank.
package i2c_reg_pkg;

  localparam int I2C_BYTE_W = 8;
  localparam int I2C_ADDR_W = 8;

  localparam logic DIR_WRITE = 1'b0;
  localparam logic DIR_READ  = 1'b1;

  localparam logic [I2C_BYTE_W-1:0] UNMAPPED_VAL_DEFAULT = 8'h00;
  localparam int                    SNAP_TIMEOUT_DEFAULT = 1024;

  typedef logic [I2C_BYTE_W-1:0] byte_t;
  typedef logic [I2C_ADDR_W-1:0] addr_t;

  function automatic byte_t sat_inc(input byte_t v);
    return (v == '1) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_ro_snapshot.sv
// Shadow copy of the read-only bytes. The copy freezes while a host walks
// through the RO region and is released on the last byte, a write or a timeout.
module i2c_ro_snapshot
  import i2c_reg_pkg::*;
#(
  parameter int RW_CNT       = 4,
  parameter int RO_CNT       = 3,
  parameter int SNAP_TIMEOUT = SNAP_TIMEOUT_DEFAULT
) (
  input  logic                         mod_clk,
  input  logic                         rst_n,
  input  logic                         commit_i,
  input  logic                         dir_i,
  input  logic [I2C_ADDR_W-1:0]        addr_i,
  input  logic [RO_CNT*I2C_BYTE_W-1:0] ro_data_i,
  output logic [RO_CNT*I2C_BYTE_W-1:0] ro_shadow_o,
  output logic                         snap_active_o
);

  localparam int              CNT_W    = (SNAP_TIMEOUT > 1) ? $clog2(SNAP_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SNAP_TIMEOUT - 1);

  logic [RO_CNT*I2C_BYTE_W-1:0] shadow_q;
  logic                         snap_q, snap_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         in_ro, is_last;

  assign in_ro   = (int'(addr_i) >= RW_CNT) && (int'(addr_i) < RW_CNT + RO_CNT);
  assign is_last = (int'(addr_i) == RW_CNT + RO_CNT - 1);

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    snap_d = snap_q;
    cnt_d  = cnt_q;
    if (commit_i) begin
      cnt_d = '0;
      if (dir_i == DIR_WRITE) begin
        snap_d = 1'b0;
      end else if (is_last) begin
        snap_d = 1'b0;
      end else if (in_ro) begin
        snap_d = 1'b1;
      end
    end else if (snap_q) begin
      if (cnt_q == CNT_LAST) begin
        snap_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge mod_clk or negedge rst_n) begin
    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    if (!rst_n) begin
      shadow_q <= '0;
      snap_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (!snap_q) shadow_q <= ro_data_i;
      snap_q <= snap_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ro_shadow_o   = shadow_q;
  assign snap_active_o = snap_q;

endmodule

// File: rtl/i2c_reg_bank.sv
// Byte-addressed register bank behind i2c_slave: RW registers with write
// strobes, snapshotted RO bytes, unmapped fill value and an illegal-write counter.
module i2c_reg_bank
  import i2c_reg_pkg::*;
#(
  parameter int                         RW_CNT       = 4,
  parameter int                         RO_CNT       = 3,
  parameter logic [RW_CNT*I2C_BYTE_W-1:0] RW_INIT    = {8'h01, 8'h02, 8'h03, 8'h04},
  parameter logic [I2C_BYTE_W-1:0]      UNMAPPED_VAL = UNMAPPED_VAL_DEFAULT,
  parameter int                         SNAP_TIMEOUT = SNAP_TIMEOUT_DEFAULT
) (
  input  logic                         mod_clk,
  input  logic                         rst_n,
  input  logic [I2C_ADDR_W-1:0]        i2c_reg_addr,
  input  logic [I2C_BYTE_W-1:0]        i2c_data_out,
  input  logic                         i2c_data_transfer_dir,
  input  logic                         i2c_data_transfer_done,
  output logic [I2C_BYTE_W-1:0]        i2c_data_in,
  input  logic [RO_CNT*I2C_BYTE_W-1:0] ro_data,
  output logic [RW_CNT*I2C_BYTE_W-1:0] rw_data,
  output logic [RW_CNT-1:0]            rw_wr_strobe,
  output logic                         snap_active,
  output logic [I2C_BYTE_W-1:0]        err_cnt
);

  logic                         done_q;
  logic                         commit, wr_commit, in_rw;
  byte_t                        rw_q [RW_CNT];
  byte_t                        rw_d [RW_CNT];
  logic [RW_CNT-1:0]            strobe_q, strobe_d;
  byte_t                        err_q, err_d;
  byte_t                        rd_q, rd_d;
  logic [RO_CNT*I2C_BYTE_W-1:0] ro_shadow;

  // done_q resets high so a done level already present at reset release never commits.
  assign commit    = i2c_data_transfer_done & ~done_q;
  assign wr_commit = commit && (i2c_data_transfer_dir == DIR_WRITE);
  assign in_rw     = int'(i2c_reg_addr) < RW_CNT;

  i2c_ro_snapshot #(
    .RW_CNT      (RW_CNT),
    .RO_CNT      (RO_CNT),
    .SNAP_TIMEOUT(SNAP_TIMEOUT)
  ) u_snapshot (
    .mod_clk      (mod_clk),
    .rst_n        (rst_n),
    .commit_i     (commit),
    .dir_i        (i2c_data_transfer_dir),
    .addr_i       (i2c_reg_addr),
    .ro_data_i    (ro_data),
    .ro_shadow_o  (ro_shadow),
    .snap_active_o(snap_active)
  );

  always_comb begin
    rw_d     = rw_q;
    strobe_d = '0;
    err_d    = err_q;
    if (wr_commit) begin
      if (in_rw) begin
        for (int i = 0; i < RW_CNT; i++) begin
          if (int'(i2c_reg_addr) == i) begin
            rw_d[i]               = i2c_data_out;
            strobe_d[RW_CNT-1-i]  = 1'b1;
          end
        end
      end else begin
        err_d = sat_inc(err_q);
      end
    end
  end

  always_comb begin
    rd_d = UNMAPPED_VAL;
    for (int i = 0; i < RW_CNT; i++) begin
      if (int'(i2c_reg_addr) == i) rd_d = rw_q[i];
    end
    for (int j = 0; j < RO_CNT; j++) begin
      if (int'(i2c_reg_addr) == RW_CNT + j) rd_d = ro_shadow[(RO_CNT-1-j)*I2C_BYTE_W +: I2C_BYTE_W];
    end
  end

  always_ff @(posedge mod_clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q   <= 1'b1;
      // NOTE: these bytes are individual control registers, not a RAM, so each gets its RW_INIT reset value.
      for (int i = 0; i < RW_CNT; i++) begin
        rw_q[i] <= RW_INIT[(RW_CNT-1-i)*I2C_BYTE_W +: I2C_BYTE_W];
      end
      strobe_q <= '0;
      err_q    <= '0;
      rd_q     <= '0;
    end else begin
      done_q   <= i2c_data_transfer_done;
      rw_q     <= rw_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
    end
  end

  for (genvar gi = 0; gi < RW_CNT; gi++) begin : g_pack
    assign rw_data[(RW_CNT-1-gi)*I2C_BYTE_W +: I2C_BYTE_W] = rw_q[gi];
  end

  assign rw_wr_strobe = strobe_q;
  assign err_cnt      = err_q;
  assign i2c_data_in  = rd_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Self-checking bench for i2c_reg_bank: per-cycle comparison against a
// transaction-level model plus directed checks with hand-computed values.
module tb_i2c_reg_bank;
  import i2c_reg_pkg::*;

  localparam int          RW_CNT = 4;
  localparam int          RO_CNT = 3;
  localparam int          T      = 1024;
  localparam logic [31:0] INIT   = 32'h01020304;

  logic        mod_clk = 1'b0;
  logic        rst_n;
  logic [7:0]  i2c_reg_addr;
  logic [7:0]  i2c_data_out;
  logic        dir;
  logic        done;
  logic [7:0]  i2c_data_in;
  logic [23:0] ro_data;
  logic [31:0] rw_data;
  logic [3:0]  rw_wr_strobe;
  logic        snap_active;
  logic [7:0]  err_cnt;

  always #5 mod_clk = ~mod_clk;

  i2c_reg_bank #(
    .RW_CNT      (RW_CNT),
    .RO_CNT      (RO_CNT),
    .RW_INIT     (INIT),
    .UNMAPPED_VAL(8'h00),
    .SNAP_TIMEOUT(T)
  ) dut (
    .mod_clk               (mod_clk),
    .rst_n                 (rst_n),
    .i2c_reg_addr          (i2c_reg_addr),
    .i2c_data_out          (i2c_data_out),
    .i2c_data_transfer_dir (dir),
    .i2c_data_transfer_done(done),
    .i2c_data_in           (i2c_data_in),
    .ro_data               (ro_data),
    .rw_data               (rw_data),
    .rw_wr_strobe          (rw_wr_strobe),
    .snap_active           (snap_active),
    .err_cnt               (err_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: bytes as arrays, snapshot expiry as an absolute cycle deadline.
  byte_t       m_rw [RW_CNT];
  byte_t       m_shadow [RO_CNT];
  logic        m_snap;
  longint      m_cyc, m_deadline;
  int          m_err;
  logic        m_prev_done;
  logic [3:0]  m_strobe;
  byte_t       m_rd;
  bit          m_ok = 0;

  function automatic byte_t m_read(input int a);
    if (a < RW_CNT) return m_rw[a];
    if (a < RW_CNT + RO_CNT) return m_shadow[a - RW_CNT];
    return 8'h00;
  endfunction

  function automatic logic [31:0] m_rw_packed();
    return {m_rw[0], m_rw[1], m_rw[2], m_rw[3]};
  endfunction

  always @(posedge mod_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RW_CNT; i++) m_rw[i] = INIT[(RW_CNT-1-i)*8 +: 8];
      for (int j = 0; j < RO_CNT; j++) m_shadow[j] = 8'h00;
      m_snap = 1'b0; m_cyc = 0; m_deadline = 0; m_err = 0;
      m_prev_done = 1'b1; m_strobe = '0; m_rd = 8'h00; m_ok = 1;
    end else begin
      int   a;
      logic c;
      m_cyc++;
      a = int'(i2c_reg_addr);
      c = done && !m_prev_done;
      m_rd = m_read(a);
      m_strobe = '0;
      if (c && dir == DIR_WRITE) begin
        if (a < RW_CNT) begin
          m_rw[a] = i2c_data_out;
          m_strobe[RW_CNT-1-a] = 1'b1;
        end else if (m_err < 255) begin
          m_err++;
        end
      end
      if (!m_snap) for (int j = 0; j < RO_CNT; j++) m_shadow[j] = ro_data[(RO_CNT-1-j)*8 +: 8];
      if (c) begin
        m_deadline = m_cyc + T;
        if (dir == DIR_WRITE) m_snap = 1'b0;
        else if (a == RW_CNT + RO_CNT - 1) m_snap = 1'b0;
        else if (a >= RW_CNT && a < RW_CNT + RO_CNT) m_snap = 1'b1;
      end else if (m_snap && m_cyc == m_deadline) begin
        m_snap = 1'b0;
      end
      m_prev_done = done;
    end
  end

  always @(negedge mod_clk) begin
    if (m_ok) begin
      check("cmp_rw_data", rw_data, m_rw_packed());
      check("cmp_strobe", {28'd0, rw_wr_strobe}, {28'd0, m_strobe});
      check("cmp_rd_byte", {24'd0, i2c_data_in}, {24'd0, m_rd});
      check("cmp_snap", {31'd0, snap_active}, {31'd0, m_snap});
      check("cmp_err_cnt", {24'd0, err_cnt}, m_err);
    end
  end

  int         pulses = 0;
  logic [3:0] last_strobe = '0;
  always @(negedge mod_clk) begin
    if (rw_wr_strobe != '0) begin
      pulses++;
      last_strobe = rw_wr_strobe;
    end
  end

  task automatic xfer(input logic d, input byte_t a, input byte_t wd, input int hold, output byte_t rd);
    @(negedge mod_clk);
    i2c_reg_addr = a; i2c_data_out = wd; dir = d; done = 1'b1;
    @(negedge mod_clk);
    rd = i2c_data_in;
    repeat (hold - 1) @(negedge mod_clk);
    done = 1'b0;
    @(negedge mod_clk);
  endtask

  byte_t sweep_exp [8];
  byte_t rd;
  int    cycles;

  initial begin
    sweep_exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h01, 8'h00, 8'h00};
    rst_n = 1'b0; done = 1'b0; dir = DIR_READ; i2c_reg_addr = 8'h00;
    i2c_data_out = 8'h00; ro_data = 24'h000100;
    repeat (3) @(negedge mod_clk);
    check("rst_rw_data", rw_data, INIT);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("rst_snap", {31'd0, snap_active}, 32'd0);
    check("rst_strobe", {28'd0, rw_wr_strobe}, 32'd0);
    check("rst_rd_byte", {24'd0, i2c_data_in}, 32'd0);
    rst_n = 1'b1;

    for (int a = 0; a < 8; a++) begin
      @(negedge mod_clk);
      i2c_reg_addr = 8'(a);
      @(negedge mod_clk);
      check($sformatf("sweep_addr%0d", a), {24'd0, i2c_data_in}, {24'd0, sweep_exp[a]});
    end

    pulses = 0;
    xfer(DIR_WRITE, 8'd2, 8'hA5, 5, rd);
    check("wr2_rw_data", rw_data, 32'h0102A504);
    check("wr2_pulses", pulses, 32'd1);
    check("wr2_strobe", {28'd0, last_strobe}, 32'h2);

    pulses = 0;
    xfer(DIR_WRITE, 8'd3, 8'h77, 1, rd);
    xfer(DIR_WRITE, 8'd3, 8'h77, 1, rd);
    check("wr3_rw_data", rw_data, 32'h0102A577);
    check("wr3_pulses", pulses, 32'd2);

    xfer(DIR_WRITE, 8'd5, 8'h55, 1, rd);
    check("err_one", {24'd0, err_cnt}, 32'd1);
    check("err_rw_same", rw_data, 32'h0102A577);
    repeat (299) xfer(DIR_WRITE, 8'd5, 8'h55, 1, rd);
    check("err_sat", {24'd0, err_cnt}, 32'hFF);

    xfer(DIR_READ, 8'd4, 8'h00, 1, rd);
    check("snap_rd4", {24'd0, rd}, 32'h00);
    check("snap_on", {31'd0, snap_active}, 32'd1);
    ro_data = 24'h020304;
    xfer(DIR_READ, 8'd5, 8'h00, 1, rd);
    check("snap_rd5", {24'd0, rd}, 32'h01);
    xfer(DIR_READ, 8'd6, 8'h00, 1, rd);
    check("snap_rd6", {24'd0, rd}, 32'h00);
    check("snap_off", {31'd0, snap_active}, 32'd0);
    xfer(DIR_READ, 8'd4, 8'h00, 1, rd);
    check("fresh_rd4", {24'd0, rd}, 32'h02);

    @(negedge mod_clk);
    i2c_reg_addr = 8'd4; dir = DIR_READ; done = 1'b1;
    @(negedge mod_clk);
    done = 1'b0; i2c_reg_addr = 8'd6; ro_data = 24'hA1B2C3; cycles = 0;
    @(negedge mod_clk);
    cycles = 1;
    check("frozen_rd6", {24'd0, i2c_data_in}, 32'h04);
    while (snap_active && cycles < 2 * T) begin
      @(negedge mod_clk);
      cycles++;
    end
    check("timeout_cycles", cycles, T);
    repeat (3) @(negedge mod_clk);
    check("tracks_rd6", {24'd0, i2c_data_in}, 32'hC3);

    pulses = 0;
    @(negedge mod_clk);
    #2;
    i2c_reg_addr = 8'd1; i2c_data_out = 8'hFF; dir = DIR_WRITE; done = 1'b1; rst_n = 1'b0;
    repeat (2) @(negedge mod_clk);
    rst_n = 1'b1;
    repeat (3) @(negedge mod_clk);
    done = 1'b0;
    repeat (2) @(negedge mod_clk);
    check("mid_rst_rw_data", rw_data, INIT);
    check("mid_rst_pulses", pulses, 32'd0);
    check("mid_rst_err", {24'd0, err_cnt}, 32'd0);
    check("mid_rst_snap", {31'd0, snap_active}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
